iic_reg_wr_master: RTL and testbench

- Byte-level I2C write engine that sits directly downstream of the MS72xx register-init sequencer.
- The sequencer hands it one (device, register, data) tuple at a time over a valid/ready handshake.
- The block serialises the tuple as a single I2C write transaction on SCL/SDA and reports completion and ACK status back.
- Runs in the 10 MHz config clock domain; one instance per I2C bus (TX and RX buses).

---
 rtl/iic_reg_wr_master.sv | 215 +++++++++++++++++++++
 tb/tb_iic_reg_wr_master.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_reg_wr_master.sv
// Byte-level I2C register write engine: one (device, register, data) tuple per transaction.
// Define IIC_RETRY_EN to restart the whole transaction after a NACK, up to RETRY_MAX times.
module iic_reg_wr_master #(
    parameter int unsigned CLK_DIV   = 25,
    parameter int unsigned REG_BYTES = 2,
    parameter int unsigned RETRY_MAX = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_dev,
    input  logic [15:0] req_reg,
    input  logic [7:0]  req_data,
    output logic        busy,
    output logic        done,
    output logic        nack,
    output logic        iic_scl,
    inout  wire         iic_sda
);
    localparam int unsigned QW     = $clog2(CLK_DIV);
    localparam int unsigned NBYTES = REG_BYTES + 2;

    if (CLK_DIV < 2 || CLK_DIV > 1023 || (REG_BYTES != 1 && REG_BYTES != 2) ||
        RETRY_MAX > 255) begin : g_param_err
        $error("iic_reg_wr_master: illegal parameter value");
    end

    typedef enum logic [2:0] {StIdle, StStart, StBit, StAck, StStop, StDone} state_e;

    state_e          state_q, state_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      quarter_q, quarter_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      byte_q, byte_d;
    logic [6:0]      dev_q, dev_d;
    logic [15:0]     reg_q, reg_d;
    logic [7:0]      data_q, data_d;
    logic            flag_q, flag_d;
    logic            ack_q, ack_d;
    logic            tick;
    logic            sda_low;
    logic [7:0]      cur_byte;
`ifdef IIC_RETRY_EN
    localparam int unsigned RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    logic [RW-1:0]   retry_q, retry_d;
`endif

    assign tick = (qcnt_q == QW'(CLK_DIV - 1));

    always_comb begin
        if (byte_q == 2'd0) begin
            cur_byte = {dev_q, 1'b0};
        end else if (byte_q == 2'(NBYTES - 1)) begin
            cur_byte = data_q;
        end else if (byte_q == 2'(NBYTES - 2)) begin
            cur_byte = reg_q[7:0];
        end else begin
            cur_byte = reg_q[15:8];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            qcnt_q    <= '0;
            quarter_q <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            dev_q     <= '0;
            reg_q     <= '0;
            data_q    <= '0;
            flag_q    <= 1'b0;
            ack_q     <= 1'b0;
`ifdef IIC_RETRY_EN
            retry_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            data_q    <= data_d;
            flag_q    <= flag_d;
            ack_q     <= ack_d;
`ifdef IIC_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        data_d    = data_q;
        flag_d    = flag_q;
        ack_d     = ack_q;
`ifdef IIC_RETRY_EN
        retry_d   = retry_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    // The acceptance cycle counts as the first clk of START q0.
                    state_d   = StStart;
                    qcnt_d    = QW'(1);
                    quarter_d = 2'd0;
                    dev_d     = req_dev;
                    reg_d     = req_reg;
                    data_d    = req_data;
                    flag_d    = 1'b0;
`ifdef IIC_RETRY_EN
                    retry_d   = '0;
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
                qcnt_d  = '0;
            end
            default: begin
                if (tick) begin
                    qcnt_d    = '0;
                    quarter_d = quarter_q + 2'd1;
                    if (state_q == StAck && quarter_q == 2'd1) begin
                        ack_d = iic_sda;
                    end
                    if (quarter_q == 2'd3) begin
                        case (state_q)
                            StStart: begin
                                state_d = StBit;
                                bit_d   = 3'd7;
                                byte_d  = 2'd0;
                            end
                            StBit: begin
                                if (bit_q == 3'd0) begin
                                    state_d = StAck;
                                end else begin
                                    bit_d = bit_q - 3'd1;
                                end
                            end
                            StAck: begin
                                if (ack_q) begin
                                    flag_d  = 1'b1;
                                    state_d = StStop;
                                end else if (byte_q == 2'(NBYTES - 1)) begin
                                    state_d = StStop;
                                end else begin
                                    state_d = StBit;
                                    byte_d  = byte_q + 2'd1;
                                    bit_d   = 3'd7;
                                end
                            end
                            StStop: begin
`ifdef IIC_RETRY_EN
                                if (flag_q && retry_q < RW'(RETRY_MAX)) begin
                                    retry_d = retry_q + 1'b1;
                                    flag_d  = 1'b0;
                                    state_d = StStart;
                                end else begin
                                    state_d = StDone;
                                end
`else
                                state_d = StDone;
`endif
                            end
                            default: ;
                        endcase
                    end
                end else begin
                    qcnt_d = qcnt_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        iic_scl = 1'b1;
        sda_low = 1'b0;
        unique case (state_q)
            StStart: begin
                iic_scl = (quarter_q < 2'd2);
                sda_low = (quarter_q != 2'd0);
            end
            StBit: begin
                iic_scl = (quarter_q == 2'd1) || (quarter_q == 2'd2);
                sda_low = ~cur_byte[bit_q];
            end
            StAck: begin
                iic_scl = (quarter_q == 2'd1) || (quarter_q == 2'd2);
            end
            StStop: begin
                iic_scl = (quarter_q != 2'd0);
                sda_low = (quarter_q < 2'd2);
            end
            default: ;
        endcase
    end

    // Open drain: SDA is only ever pulled low or released.
    assign iic_sda   = sda_low ? 1'b0 : 1'bz;
    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle) && (state_q != StDone);
    assign done      = (state_q == StDone);
    assign nack      = (state_q == StDone) && flag_q;

endmodule

// File: tb/tb_iic_reg_wr_master.sv
// Bench for iic_reg_wr_master: bus monitor + ACKing slave model, byte scoreboard per transaction.
module tb_iic_reg_wr_master;
    localparam int unsigned CD_A    = 25;
    localparam int unsigned CD_B    = 4;
    localparam int unsigned RETRIES = 3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic [6:0]  req_dev = '0;
    logic [15:0] req_reg = '0;
    logic [7:0]  req_data = '0;
    logic        sel = 1'b0;
    logic        slave_low = 1'b0;
    int          nack_byte = -1;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;

    wire ready_a, busy_a, done_a, nack_a, scl_a, sda_a;
    wire ready_b, busy_b, done_b, nack_b, scl_b, sda_b;
    wire valid_a = req_valid & ~sel;
    wire valid_b = req_valid & sel;

    pullup (sda_a);
    pullup (sda_b);
    assign sda_a = (slave_low && !sel) ? 1'b0 : 1'bz;
    assign sda_b = (slave_low && sel) ? 1'b0 : 1'bz;

    iic_reg_wr_master #(.CLK_DIV(CD_A), .REG_BYTES(2), .RETRY_MAX(RETRIES)) u_dut_a (
        .clk(clk), .rstn(rstn), .req_valid(valid_a), .req_ready(ready_a), .req_dev(req_dev),
        .req_reg(req_reg), .req_data(req_data), .busy(busy_a), .done(done_a), .nack(nack_a),
        .iic_scl(scl_a), .iic_sda(sda_a)
    );

    iic_reg_wr_master #(.CLK_DIV(CD_B), .REG_BYTES(1), .RETRY_MAX(RETRIES)) u_dut_b (
        .clk(clk), .rstn(rstn), .req_valid(valid_b), .req_ready(ready_b), .req_dev(req_dev),
        .req_reg(req_reg), .req_data(req_data), .busy(busy_b), .done(done_b), .nack(nack_b),
        .iic_scl(scl_b), .iic_sda(sda_b)
    );

    wire ready_s = sel ? ready_b : ready_a;
    wire done_s  = sel ? done_b : done_a;
    wire nack_s  = sel ? nack_b : nack_a;
    wire m_scl   = sel ? scl_b : scl_a;
    wire m_sda   = sel ? sda_b : sda_a;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard entries are {bus, ack bit seen (1 = NACK), byte}.
    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];
    int         acc_q[$];
    int         done_cyc_q[$];
    logic       done_nack_q[$];

    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    int         bitn = 0;
    int         byte_n = 0;
    logic [7:0] sh = '0;
    int         start_cnt = 0;
    int         stop_cnt = 0;

    always @(negedge clk) begin
        if (p_scl && m_scl && p_sda && !m_sda) begin
            start_cnt <= start_cnt + 1;
            bitn      <= 0;
            byte_n    <= 0;
            slave_low <= 1'b0;
        end else if (p_scl && m_scl && !p_sda && m_sda) begin
            stop_cnt <= stop_cnt + 1;
            bitn     <= 0;
        end else if (!p_scl && m_scl) begin
            if (bitn < 8) sh <= {sh[6:0], m_sda};
            else obs_q.push_back({sel, m_sda, sh});
            bitn <= bitn + 1;
        end else if (p_scl && !m_scl) begin
            if (bitn == 8) begin
                slave_low <= (byte_n != nack_byte);
            end else if (bitn == 9) begin
                slave_low <= 1'b0;
                bitn      <= 0;
                byte_n    <= byte_n + 1;
            end
        end
        if (rstn && req_valid && ready_s) acc_q.push_back(cyc);
        if (done_s) begin
            done_cyc_q.push_back(cyc);
            done_nack_q.push_back(nack_s);
        end
        p_scl <= m_scl;
        p_sda <= m_sda;
    end

    task automatic expect_bytes(input logic bus, input logic [6:0] d, input logic [15:0] r,
                                input logic [7:0] v, input int nbytes, input int nack_at);
        logic [7:0] seq[$];
        seq.push_back({d, 1'b0});
        if (nbytes == 4) seq.push_back(r[15:8]);
        seq.push_back(r[7:0]);
        seq.push_back(v);
        for (int i = 0; i < nbytes; i++) begin
            exp_q.push_back({bus, (i == nack_at), seq[i]});
            if (i == nack_at) break;
        end
    endtask

    task automatic drive_req(input logic [6:0] d, input logic [15:0] r, input logic [7:0] v);
        @(negedge clk);
        req_dev = d;
        req_reg = r;
        req_data = v;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc, output logic dnack);
        int n = 0;
        while (done_cyc_q.size() == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cyc_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done within %0d cycles", budget);
            dcyc = -1;
            dnack = 1'bx;
        end else begin
            dcyc = done_cyc_q.pop_front();
            dnack = done_nack_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        repeat (100) @(negedge clk);
        vectors++;
        if (scl_a !== 1'b1) begin miscompares++; $display("FAIL rst_scl: got %b want 1", scl_a); end
        vectors++;
        if (sda_a !== 1'b1) begin miscompares++; $display("FAIL rst_sda: got %b want 1", sda_a); end
        vectors++;
        if (ready_a !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", ready_a); end
        vectors++;
        if (busy_a !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy_a); end
        vectors++;
        if (nack_a !== 1'b0) begin miscompares++; $display("FAIL rst_nack: got %b want 0", nack_a); end
        vectors++;
        if (done_cyc_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_done: got %0d pulses want 0", done_cyc_q.size());
        end
        vectors++;
        if (scl_b !== 1'b1 || ready_b !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_b: got scl=%b ready=%b want 1 1", scl_b, ready_b);
        end
    endtask

    task automatic test_write_ack();
        int dcyc, acc, s0, p0;
        logic dn;
        logic [9:0] ew, ow;
        sel = 1'b0;
        nack_byte = -1;
        s0 = start_cnt;
        p0 = stop_cnt;
        acc_q.delete();
        expect_bytes(1'b0, 7'h2B, 16'h1234, 8'hA5, 4, -1);
        drive_req(7'h2B, 16'h1234, 8'hA5);
        vectors++;
        if (ready_a !== 1'b0 || busy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL ack_hs: got ready=%b busy=%b want 0 1", ready_a, busy_a);
        end
        wait_done(6000, dcyc, dn);
        acc = (acc_q.size() > 0) ? acc_q.pop_front() : -100000;
        vectors++;
        if (dn !== 1'b0) begin miscompares++; $display("FAIL ack_nack: got %b want 0", dn); end
        vectors++;
        if (dcyc - acc != 3800) begin
            miscompares++;
            $display("FAIL ack_latency: got %0d want 3800", dcyc - acc);
        end
        vectors++;
        if (start_cnt - s0 != 1 || stop_cnt - p0 != 1) begin
            miscompares++;
            $display("FAIL ack_framing: got %0d starts %0d stops want 1 1", start_cnt - s0,
                     stop_cnt - p0);
        end
        while (exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL ack_byte: got nothing want %h", ew);
            end else begin
                ow = obs_q.pop_front();
                if (ow !== ew) begin miscompares++; $display("FAIL ack_byte: got %h want %h", ow, ew); end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL ack_extra: got %0d extra bytes want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_nack();
        int dcyc, s0, p0, attempts;
        logic dn;
        logic [9:0] ew, ow;
`ifdef IIC_RETRY_EN
        attempts = RETRIES + 1;
`else
        attempts = 1;
`endif
        sel = 1'b0;
        nack_byte = 1;
        s0 = start_cnt;
        p0 = stop_cnt;
        for (int a = 0; a < attempts; a++) expect_bytes(1'b0, 7'h2B, 16'h1234, 8'hA5, 4, 1);
        drive_req(7'h2B, 16'h1234, 8'hA5);
        wait_done(12000, dcyc, dn);
        vectors++;
        if (dn !== 1'b1) begin miscompares++; $display("FAIL nack_flag: got %b want 1", dn); end
        vectors++;
        if (start_cnt - s0 != attempts || stop_cnt - p0 != attempts) begin
            miscompares++;
            $display("FAIL nack_attempts: got %0d starts %0d stops want %0d", start_cnt - s0,
                     stop_cnt - p0, attempts);
        end
        while (exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL nack_byte: got nothing want %h", ew);
            end else begin
                ow = obs_q.pop_front();
                if (ow !== ew) begin miscompares++; $display("FAIL nack_byte: got %h want %h", ow, ew); end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL nack_extra: got %0d extra bytes want 0", obs_q.size());
            obs_q.delete();
        end
        nack_byte = -1;
    endtask

    task automatic test_short_reg();
        int dcyc, acc;
        logic dn;
        logic [9:0] ew, ow;
        sel = 1'b1;
        nack_byte = -1;
        acc_q.delete();
        expect_bytes(1'b1, 7'h2B, 16'h00FF, 8'h3C, 3, -1);
        drive_req(7'h2B, 16'h00FF, 8'h3C);
        wait_done(1000, dcyc, dn);
        acc = (acc_q.size() > 0) ? acc_q.pop_front() : -100000;
        vectors++;
        if (dn !== 1'b0) begin miscompares++; $display("FAIL short_nack: got %b want 0", dn); end
        vectors++;
        if (dcyc - acc != 464) begin
            miscompares++;
            $display("FAIL short_latency: got %0d want 464", dcyc - acc);
        end
        while (exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL short_byte: got nothing want %h", ew);
            end else begin
                ow = obs_q.pop_front();
                if (ow !== ew) begin miscompares++; $display("FAIL short_byte: got %h want %h", ow, ew); end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL short_extra: got %0d extra bytes want 0", obs_q.size());
            obs_q.delete();
        end
        repeat (5) @(posedge clk);
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        int d1, d2, a1, a2, n;
        logic n1, n2;
        logic [9:0] ew, ow;
        sel = 1'b0;
        nack_byte = -1;
        acc_q.delete();
        expect_bytes(1'b0, 7'h50, 16'hBEEF, 8'h11, 4, -1);
        expect_bytes(1'b0, 7'h1A, 16'h0102, 8'hC3, 4, -1);
        @(negedge clk);
        req_dev = 7'h50;
        req_reg = 16'hBEEF;
        req_data = 8'h11;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_dev = 7'h1A;
        req_reg = 16'h0102;
        req_data = 8'hC3;
        wait_done(6000, d1, n1);
        n = 0;
        while (acc_q.size() < 2 && n < 10) begin
            @(posedge clk);
            n++;
        end
        #1;
        req_dev = 7'h7F;
        req_reg = 16'hFFFF;
        req_data = 8'h00;
        req_valid = 1'b0;
        vectors++;
        if (acc_q.size() < 2) begin
            miscompares++;
            $display("FAIL b2b_accept: got %0d acceptances want 2", acc_q.size());
        end else begin
            a1 = acc_q.pop_front();
            a2 = acc_q.pop_front();
            if (a2 != d1 + 1) begin
                miscompares++;
                $display("FAIL b2b_accept: got cycle %0d want %0d", a2, d1 + 1);
            end
        end
        wait_done(6000, d2, n2);
        vectors++;
        if (n1 !== 1'b0 || n2 !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_nack: got %b %b want 0 0", n1, n2);
        end
        while (exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL b2b_byte: got nothing want %h", ew);
            end else begin
                ow = obs_q.pop_front();
                if (ow !== ew) begin miscompares++; $display("FAIL b2b_byte: got %h want %h", ow, ew); end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_extra: got %0d extra bytes want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int n, dcyc;
        logic dn;
        logic [9:0] ew, ow;
        sel = 1'b0;
        nack_byte = -1;
        drive_req(7'h2B, 16'h1234, 8'hA5);
        n = 0;
        while (!(byte_n == 3 && bitn >= 2) && n < 6000) begin
            @(posedge clk);
            n++;
        end
        vectors++;
        if (!(byte_n == 3 && bitn >= 2)) begin
            miscompares++;
            $display("FAIL mid_reach: got byte %0d bit %0d want byte 3 bit 2", byte_n, bitn);
        end
        // Two data bits seen; land inside bit 5 q0 with SCL low.
        repeat (CD_A * 3 + CD_A / 2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        vectors++;
        if (scl_a !== 1'b1 || sda_a !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_bus: got scl=%b sda=%b want 1 1", scl_a, sda_a);
        end
        vectors++;
        if (busy_a !== 1'b0 || ready_a !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_state: got busy=%b ready=%b want 0 1", busy_a, ready_a);
        end
        repeat (5) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        repeat (10) @(posedge clk);
        vectors++;
        if (done_cyc_q.size() != 0) begin
            miscompares++;
            $display("FAIL mid_done: got %0d pulses want 0", done_cyc_q.size());
            done_cyc_q.delete();
            done_nack_q.delete();
        end
        obs_q.delete();
        exp_q.delete();
        expect_bytes(1'b0, 7'h33, 16'h5AC3, 8'h0F, 4, -1);
        drive_req(7'h33, 16'h5AC3, 8'h0F);
        wait_done(6000, dcyc, dn);
        vectors++;
        if (dn !== 1'b0) begin miscompares++; $display("FAIL mid_after_nack: got %b want 0", dn); end
        while (exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL mid_byte: got nothing want %h", ew);
            end else begin
                ow = obs_q.pop_front();
                if (ow !== ew) begin miscompares++; $display("FAIL mid_byte: got %h want %h", ow, ew); end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL mid_extra: got %0d extra bytes want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_write_ack();
        test_nack();
        test_short_reg();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
